// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave speaking the ADXL362 register protocol (write 0x0A, read 0x0B).
// Define SPI_FIFO_READ_EN to add the FIFO read command 0x0D.
module spi_slave_responder #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ncs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              fifo_rd_o,
    input  logic [7:0]        fifo_rdata_i,
    output logic              cmd_err_o
);

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;
`ifdef SPI_FIFO_READ_EN
    localparam logic [BYTE_W-1:0] CMD_FIFO  = 8'h0D;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WADDR,
        ST_RADDR,
        ST_WDATA,
        ST_RDATA,
        ST_FIFO,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_p, ncs_p, mosi_p;
    logic [SYNC_STAGES:0]   fill;
    logic                   sck_d, ncs_d;
    logic                   sck_s, ncs_s, mosi_s, sync_ok;
    logic                   sck_rise, sck_fall, ncs_rise, ncs_fall, byte_done;

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0]   rx_sr, rx_sr_nxt, rx_shift;
    logic [BYTE_W-1:0]   tx_sr, tx_sr_nxt;
    logic [BYTE_W-1:0]   ld_data;
    logic                ld_pend;
    logic                miso_nxt, wr_nxt, rd_nxt, fifo_rd_nxt, err_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [BYTE_W-1:0]   wdata_nxt;

    // Input synchronizers plus edge-detect stage. ncs idles high so a low ncs
    // held across reset never looks like a fresh fall; fill masks events until
    // the pipeline carries real samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_p  <= '0;
            ncs_p  <= '1;
            mosi_p <= '0;
            sck_d  <= 1'b0;
            ncs_d  <= 1'b1;
            fill   <= '0;
        end else begin
            sck_p  <= {sck_p[SYNC_STAGES-2:0], sck_i};
            ncs_p  <= {ncs_p[SYNC_STAGES-2:0], ncs_i};
            mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi_i};
            sck_d  <= sck_s;
            ncs_d  <= ncs_s;
            fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s     = sck_p[SYNC_STAGES-1];
    assign ncs_s     = ncs_p[SYNC_STAGES-1];
    assign mosi_s    = mosi_p[SYNC_STAGES-1];
    assign sync_ok   = fill[SYNC_STAGES];
    assign sck_rise  = sync_ok &  sck_s & ~sck_d;
    assign sck_fall  = sync_ok & ~sck_s &  sck_d;
    assign ncs_rise  = sync_ok &  ncs_s & ~ncs_d;
    assign ncs_fall  = sync_ok & ~ncs_s &  ncs_d;
    assign rx_shift  = {rx_sr[BYTE_W-2:0], mosi_s};
    assign byte_done = sck_rise & (bit_cnt == 3'd7);

`ifdef SPI_FIFO_READ_EN
    logic ld_fifo;

    always_ff @(posedge clk_i) begin
        if (rst_i) ld_fifo <= 1'b0;
        else       ld_fifo <= fifo_rd_o;
    end

    assign ld_data = ld_fifo ? fifo_rdata_i : reg_rdata_i;
`else
    logic unused_fifo_rdata;
    assign unused_fifo_rdata = ^fifo_rdata_i;
    assign ld_data = reg_rdata_i;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            ld_pend     <= 1'b0;
            miso_o      <= 1'b0;
            busy_o      <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            fifo_rd_o   <= 1'b0;
            cmd_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_sr       <= rx_sr_nxt;
            tx_sr       <= tx_sr_nxt;
            ld_pend     <= reg_rd_o | fifo_rd_o;
            miso_o      <= miso_nxt;
            busy_o      <= ~ncs_s;
            reg_addr_o  <= addr_nxt;
            reg_wdata_o <= wdata_nxt;
            reg_wr_o    <= wr_nxt;
            reg_rd_o    <= rd_nxt;
            fifo_rd_o   <= fifo_rd_nxt;
            cmd_err_o   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_sr_nxt   = rx_sr;
        tx_sr_nxt   = tx_sr;
        addr_nxt    = reg_addr_o;
        wdata_nxt   = reg_wdata_o;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        fifo_rd_nxt = 1'b0;
        err_nxt     = 1'b0;

        // Write address advances the cycle after each write strobe.
        if (reg_wr_o) addr_nxt = reg_addr_o + ADDR_W'(1);

        // Returned read data lands one clk after the request; the fall right
        // after a byte boundary (counter 0) must keep the fresh MSB in place.
        if (ld_pend) begin
            tx_sr_nxt = ld_data;
        end else if (sck_fall && bit_cnt != 3'd0) begin
            tx_sr_nxt = {tx_sr[BYTE_W-2:0], 1'b0};
        end

        if (ncs_rise) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 3'd0;
        end else if (state == ST_IDLE) begin
            bit_cnt_nxt = 3'd0;
            if (ncs_fall) state_nxt = ST_CMD;
        end else begin
            if (sck_rise) begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                rx_sr_nxt   = rx_shift;
            end
            if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        case (rx_shift)
                            CMD_WRITE: state_nxt = ST_WADDR;
                            CMD_READ:  state_nxt = ST_RADDR;
`ifdef SPI_FIFO_READ_EN
                            CMD_FIFO: begin
                                state_nxt   = ST_FIFO;
                                fifo_rd_nxt = 1'b1;
                            end
`endif
                            default: begin
                                state_nxt = ST_IGNORE;
                                err_nxt   = 1'b1;
                            end
                        endcase
                    end
                    ST_WADDR: begin
                        addr_nxt  = rx_shift[ADDR_W-1:0];
                        state_nxt = ST_WDATA;
                    end
                    ST_RADDR: begin
                        addr_nxt  = rx_shift[ADDR_W-1:0];
                        rd_nxt    = 1'b1;
                        state_nxt = ST_RDATA;
                    end
                    ST_WDATA: begin
                        wdata_nxt = rx_shift;
                        wr_nxt    = 1'b1;
                    end
                    ST_RDATA: begin
                        addr_nxt = reg_addr_o + ADDR_W'(1);
                        rd_nxt   = 1'b1;
                    end
                    ST_FIFO: fifo_rd_nxt = 1'b1;
                    default: ;
                endcase
            end
        end

        miso_nxt = ((state_nxt == ST_RDATA) || (state_nxt == ST_FIFO)) ? tx_sr_nxt[BYTE_W-1] : 1'b0;
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: acts as SPI master plus external register file / FIFO.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic       clk, rst, sck, ncs, mosi;
    logic       miso, busy, reg_wr, reg_rd, fifo_rd, cmd_err;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata, fifo_rdata;

    spi_slave_responder #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sck_i        (sck),
        .ncs_i        (ncs),
        .mosi_i       (mosi),
        .miso_o       (miso),
        .busy_o       (busy),
        .reg_addr_o   (reg_addr),
        .reg_wdata_o  (reg_wdata),
        .reg_wr_o     (reg_wr),
        .reg_rd_o     (reg_rd),
        .reg_rdata_i  (reg_rdata),
        .fifo_rd_o    (fifo_rd),
        .fifo_rdata_i (fifo_rdata),
        .cmd_err_o    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file and FIFO with 1-cycle read latency; data is only
    // valid for the one cycle after the request.
    logic [7:0] mem [0:63] = '{8: 8'hA5, 9: 8'h3C, 10: 8'hF0, default: 8'h00};
    logic [7:0] fifo_src [0:3] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int         fifo_ptr = 0;
    int         err_cnt  = 0;
    int         fifo_cnt = 0;
    logic [5:0] wa_log [$];
    logic [7:0] wd_log [$];
    logic [5:0] rd_log [$];

    always @(posedge clk) begin
        reg_rdata  <= 8'h5A;
        fifo_rdata <= 8'hC3;
        if (reg_rd) begin
            reg_rdata <= mem[reg_addr];
            rd_log.push_back(reg_addr);
        end
        if (reg_wr) begin
            mem[reg_addr] <= reg_wdata;
            wa_log.push_back(reg_addr);
            wd_log.push_back(reg_wdata);
        end
        if (fifo_rd) begin
            fifo_rdata <= fifo_src[fifo_ptr[1:0]];
            fifo_ptr   <= fifo_ptr + 1;
            fifo_cnt   <= fifo_cnt + 1;
        end
        if (cmd_err) err_cnt <= err_cnt + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Shift n bits MSB first; MISO captured at each SCLK rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            r[7-i] = miso;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Byte 0 of every packed byte field sits in bits [7:0].
    typedef struct packed {
        logic [4:0][7:0] tx;
        logic [4:0][7:0] exp_rx;
        logic [4:0]      chk_rx;
        logic [2:0]      n_bytes;
        logic [2:0]      part_bits;
        logic [3:0]      exp_wr;
        logic [3:0]      exp_rd;
        logic [3:0]      exp_err;
        logic [3:0]      exp_fifo;
        logic [7:0]      wa0, wd0, wa1, wd1, ra0;
    } vec_t;

    function automatic vec_t mk(input logic [39:0] tx, input int n, input int part,
                                input logic [39:0] rx, input logic [4:0] chk,
                                input int wr, input int rd, input int er, input int ff,
                                input logic [7:0] wa0, input logic [7:0] wd0,
                                input logic [7:0] wa1, input logic [7:0] wd1,
                                input logic [7:0] ra0);
        vec_t v;
        v.tx = tx;          v.exp_rx = rx;        v.chk_rx = chk;
        v.n_bytes = 3'(n);  v.part_bits = 3'(part);
        v.exp_wr = 4'(wr);  v.exp_rd = 4'(rd);    v.exp_err = 4'(er);  v.exp_fifo = 4'(ff);
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.ra0 = ra0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int bwr, brd, berr, bff;
        logic [7:0] r;
        bwr = wa_log.size(); brd = rd_log.size(); berr = err_cnt; bff = fifo_cnt;
        cs_low();
        check($sformatf("v%0d_busy_hi", idx), 32'(busy), 32'd1);
        for (int b = 0; b < int'(v.n_bytes); b++) begin
            spi_bits(v.tx[b], 8, r);
            if (v.chk_rx[b]) check($sformatf("v%0d_miso_b%0d", idx, b), 32'(r), 32'(v.exp_rx[b]));
        end
        if (v.part_bits != 3'd0) spi_bits(v.tx[v.n_bytes], int'(v.part_bits), r);
        cs_high();
        check($sformatf("v%0d_busy_lo", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_wr_cnt", idx), 32'(wa_log.size() - bwr), 32'(v.exp_wr));
        check($sformatf("v%0d_rd_cnt", idx), 32'(rd_log.size() - brd), 32'(v.exp_rd));
        check($sformatf("v%0d_err_cnt", idx), 32'(err_cnt - berr), 32'(v.exp_err));
        check($sformatf("v%0d_fifo_cnt", idx), 32'(fifo_cnt - bff), 32'(v.exp_fifo));
        if (v.exp_wr >= 4'd1 && wa_log.size() > bwr) begin
            check($sformatf("v%0d_wa0", idx), 32'(wa_log[bwr]), 32'(v.wa0));
            check($sformatf("v%0d_wd0", idx), 32'(wd_log[bwr]), 32'(v.wd0));
        end
        if (v.exp_wr >= 4'd2 && wa_log.size() > bwr + 1) begin
            check($sformatf("v%0d_wa1", idx), 32'(wa_log[bwr+1]), 32'(v.wa1));
            check($sformatf("v%0d_wd1", idx), 32'(wd_log[bwr+1]), 32'(v.wd1));
        end
        for (int k = 0; k < int'(v.exp_rd); k++) begin
            if (rd_log.size() > brd + k)
                check($sformatf("v%0d_ra%0d", idx, k), 32'(rd_log[brd+k]), 32'(6'(v.ra0 + 8'(k))));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [0:7];

    initial begin
        int bwr, brd, berr;
        logic [7:0] r;

        vecs[0] = mk(40'h00_00_52_1F_0A, 3, 0, 40'h0, 5'b00111, 1, 0, 0, 0, 8'h1F, 8'h52, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(40'h00_00_00_08_0B, 5, 0, 40'hF0_3C_A5_00_00, 5'b11111, 0, 4, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08);
        vecs[2] = mk(40'h00_22_11_3F_0A, 4, 0, 40'h0, 5'b01111, 2, 0, 0, 0, 8'h3F, 8'h11, 8'h00, 8'h22, 8'h00);
        vecs[3] = mk(40'h00_00_C0_05_0A, 2, 4, 40'h0, 5'b00011, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[4] = mk(40'h00_00_77_06_0A, 3, 0, 40'h0, 5'b00111, 1, 0, 0, 0, 8'h06, 8'h77, 8'h00, 8'h00, 8'h00);
        vecs[5] = mk(40'h00_00_00_00_55, 3, 0, 40'h0, 5'b00111, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(40'h00_00_00_3F_0B, 4, 0, 40'h00_22_11_00_00, 5'b01111, 0, 3, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F);
`ifdef SPI_FIFO_READ_EN
        vecs[7] = mk(40'h00_00_00_00_0D, 3, 0, 40'h00_02_01_00_00, 5'b00111, 0, 0, 0, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`else
        vecs[7] = mk(40'h00_00_00_00_0D, 3, 0, 40'h0, 5'b00111, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

        rst = 1'b1; ncs = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ctrl", 32'({miso, busy, reg_wr, reg_rd, fifo_rd, cmd_err}), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of a write: outputs clear at once and the held-low
        // ncs must not restart a transaction.
        bwr = wa_log.size(); brd = rd_log.size(); berr = err_cnt;
        cs_low();
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h10, 8, r);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_addr", 32'(reg_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h33, 8, r);
        spi_bits(8'h44, 8, r);
        cs_high();
        check("midrst_wr_cnt", 32'(wa_log.size() - bwr), 32'd0);
        check("midrst_rd_cnt", 32'(rd_log.size() - brd), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt - berr), 32'd0);
        run_vec(mk(40'h00_00_44_12_0A, 3, 0, 40'h0, 5'b00111, 1, 0, 0, 0, 8'h12, 8'h44, 8'h00, 8'h00, 8'h00), 8);

        // ncs high for a single clk: the following fall must still start a transaction.
        bwr = wa_log.size();
        cs_low();
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h20, 8, r);
        spi_bits(8'h66, 8, r);
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h21, 8, r);
        spi_bits(8'h77, 8, r);
        cs_high();
        check("b2b_wr_cnt", 32'(wa_log.size() - bwr), 32'd2);
        if (wa_log.size() >= bwr + 2) begin
            check("b2b_wa0", 32'(wa_log[bwr]), 32'h20);
            check("b2b_wd0", 32'(wd_log[bwr]), 32'h66);
            check("b2b_wa1", 32'(wa_log[bwr+1]), 32'h21);
            check("b2b_wd1", 32'(wd_log[bwr+1]), 32'h77);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
Synthesizable SPI slave (mode 0) implementing the ADXL362 command protocol: write register (0x0A), read register (0x0B), and optionally read FIFO (0x0D). It is the responder end for the FPGA SPI master; it lets the master be tested in hardware loopback and also serves as a reusable register-access slave. All SPI inputs are oversampled by clk_i. Register storage is external and reached through a simple strobe interface with fixed 1-cycle read latency.

Parameters:
ADDR_W, 6, register address width; low ADDR_W bits of the address byte are used.
SYNC_STAGES, 2, flip-flop synchronizer depth on sck_i, ncs_i and mosi_i (minimum 2).

Ports:
clk_i  in  1  system clock; frequency must be at least 12x the SCLK frequency.
rst_i  in  1  synchronous, active-high reset.
sck_i  in  1  SPI clock, CPOL=0.
ncs_i  in  1  SPI chip select, active low.
mosi_i  in  1  SPI data from master, MSB first.
miso_o  out  1  SPI data to master, MSB first.
busy_o  out  1  high while synchronized ncs is low.
reg_addr_o  out  ADDR_W  current register address.
reg_wdata_o  out  8  write data, valid with reg_wr_o.
reg_wr_o  out  1  1-cycle write strobe.
reg_rd_o  out  1  1-cycle read request.
reg_rdata_i  in  8  read data, sampled exactly 1 clk after reg_rd_o.
fifo_rd_o  out  1  1-cycle FIFO pop (SPI_FIFO_READ_EN only).
fifo_rdata_i  in  8  FIFO data, sampled 1 clk after fifo_rd_o.
cmd_err_o  out  1  1-cycle pulse when an unrecognized command byte completes.

Behaviour:
- Reset values: miso_o=0, busy_o=0, reg_addr_o=0, reg_wdata_o=0, and all strobes 0. State=IDLE, bit counter=0, shift registers=0.
- Synchronizer: SYNC_STAGES flops per input, then one register for edge detection. sck rise/fall events are single-cycle pulses. mosi is sampled on the rise event.
- Bit counter (3 bits): increments on each rise event and wraps 7->0. A byte completes on the rise event that wraps it. The rx shift register shifts in MSB first.
- States:
  - IDLE: on ncs fall -> CMD, counter=0.
  - CMD: on byte complete, 0x0A->WADDR, 0x0B->RADDR, 0x0D->FIFO (macro only). Any other value -> IGNORE with a cmd_err_o pulse.
  - WADDR/RADDR: on byte complete, reg_addr_o<=byte[ADDR_W-1:0], then -> WDATA or RDATA. On entry to RDATA, reg_rd_o pulses the same cycle the address loads.
  - WDATA: on each byte complete, reg_wdata_o<=byte and reg_wr_o pulses 1 cycle with the current reg_addr_o. reg_addr_o increments the following cycle.
  - RDATA: on each byte complete, reg_addr_o increments and reg_rd_o pulses with the new address.
  - IGNORE: miso_o=0 until ncs rises.
- MISO path:
  - 1 clk after reg_rd_o/fifo_rd_o, the tx shift register loads the returned data, and miso_o = tx[7] immediately.
  - On fall events, tx shifts left only when counter != 0; the fall following a byte boundary must not shift the freshly loaded byte.
  - miso_o=0 in IDLE, CMD, WADDR, RADDR, WDATA and IGNORE.
- Address wrap: increment wraps 2^ADDR_W-1 -> 0.
- ncs rise (synchronized) in any state -> IDLE next cycle:
  - a partial byte is discarded, with no reg_wr_o;
  - miso_o=0 and counter=0.
  - A new ncs fall in the cycle after the return to IDLE is honoured.
- Rise and fall events can never coincide, because they come from one synchronized signal.
- rst_i asserted mid-transaction forces all reset values next clk. The slave then waits in IDLE for a fresh ncs fall; it does not resume on the current low ncs.
- busy_o = synchronized ~ncs.

Optional Feature:
SPI_FIFO_READ_EN:
- Defined: command 0x0D -> FIFO state with no address byte. fifo_rd_o pulses on CMD byte completion and on each subsequent byte completion. Returned fifo_rdata_i is shifted out exactly as in RDATA. reg_addr_o is unchanged.
- Undefined: 0x0D is an unrecognized command (IGNORE with a cmd_err_o pulse), fifo_rd_o is tied to 0, and fifo_rdata_i is unused.

Test Plan:
1. Write: ncs low, send 0x0A, 0x1F, 0x52, ncs high -> one reg_wr_o pulse with addr=0x1F and wdata=0x52. No reg_rd_o.
2. Read burst: external regs at 0x08/0x09/0x0A hold 0xA5/0x3C/0xF0; send 0x0B, 0x08, then three dummy bytes -> miso returns 0xA5, 0x3C, 0xF0 and reg_rd_o fires for addr 0x08, 0x09, 0x0A, 0x0B.
3. Wrap: send 0x0A, 0x3F, then bytes 0x11, 0x22 -> writes 0x11@0x3F, then 0x22@0x00.
4. Abort: send 0x0A, 0x05, then 4 bits of data and raise ncs -> no reg_wr_o, busy_o=0, state IDLE. A following full write to 0x06 succeeds.
5. Bad command: send 0x55, 0x00, 0x00 -> one cmd_err_o pulse, miso_o=0 throughout, no strobes.
6. FIFO (macro defined): fifo returns 0x01, 0x02; send 0x0D plus two dummy bytes -> miso returns 0x01, 0x02 and fifo_rd_o pulses 3 times. With the macro undefined -> cmd_err_o pulses and fifo_rd_o stays 0.
